onehot_scan_decoder: RTL and testbench
======================================

# onehot_scan_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two modes:
- **Direct:** decodes an index accepted over a valid/ready handshake.
- **Scan:** auto-steps the active output through all 2^SEL_W lines at a programmable dwell rate, for display-digit and LED-column multiplexing.

It sits between control logic and the output drivers. It generalises the fixed 3-to-8 combinational decoder with width, registered outputs, enable, handshake and sequencing.

## Interface
- SEL_W, 3, index width; output width N = 2^SEL_W
- DWELL_W, 8, width of dwell count
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  block enable; 0 forces outputs off and freezes state
- mode  in  1  0 = direct, 1 = scan
- sel  in  SEL_W  index to decode (direct) or scan start index (scan)
- sel_valid  in  1  sel is presented
- sel_ready  out  1  block accepts sel this cycle
- dwell  in  DWELL_W  cycles per scan step minus one
- y  out  N  registered one-hot output
- y_valid  out  1  y carries a decoded index
- idx  out  SEL_W  index currently driven on y
- wrap  out  1  one-cycle pulse when scan steps from N-1 to 0

## Operation
- **Reset (rst_n=0 at an edge):**
  - state IDLE; y=0, y_valid=0, idx=0, wrap=0, sel_ready=0; dwell counter=0.
  - Reset has priority over everything, including mid-scan.
- **Accept and output invariants:**
  - sel_ready = en (combinational). An accept is sel_valid && sel_ready.
  - Whenever y_valid=1, y == 1<<idx, exactly one bit set. Whenever y_valid=0, y == 0.
- **States:**
  - IDLE: y_valid=0.
    - Accept with mode=0 → DIRECT, idx=sel.
    - en && mode=1 → SCAN; idx=sel if accepted this cycle, else 0.
  - DIRECT: idx holds until the next accept, which loads sel.
    - mode=1 → SCAN, continuing from the current idx, dwell counter cleared.
  - SCAN: dwell counter counts 0..dwell. When it equals dwell, idx increments modulo N and the counter clears.
    - Stepping from N-1 to 0 asserts wrap for one cycle.
    - mode=0 → DIRECT, holding the current idx; wrap is not asserted.
- **Dwell rules:**
  - dwell is sampled every cycle; a change takes effect from the current count.
  - If the count already exceeds the new dwell, the next cycle steps.
  - dwell=0 → step every cycle.
- **Accept in SCAN:** idx=sel, dwell counter cleared, no step and no wrap that cycle. Load wins over a coincident step.
- **en=0:** y=0, y_valid=0, wrap=0. State, idx and dwell counter hold. Re-enabling resumes at the same idx and count.
- Arithmetic: idx increment wraps naturally in SEL_W bits; dwell counter is DWELL_W bits and never exceeds dwell.

## Timing
- Direct latency: accept at edge k → y, idx, y_valid updated at edge k+1 (one-cycle registered).
- Scan period: a step occurs every dwell+1 cycles; full rotation = N·(dwell+1) cycles.
- wrap is high for exactly the cycle in which idx first reads 0 after N-1.
- y, y_valid, idx and wrap are all registered; sel_ready is the only combinational output.
- IDLE→SCAN: the first y_valid=1 appears one cycle after en && mode=1 is sampled.

## Structure
- Shared package onehot_dec_pkg holds:
  - state encodings IDLE/DIRECT/SCAN as localparams (2-bit);
  - the onehot width function N = 1<<SEL_W.
- One sub-module, dwell_timer (DWELL_W parameter; inputs clk, rst_n, run, clear, dwell; output step), produces the step strobe.
- Top module holds the FSM, idx register, output decode register and wrap logic.

## Test plan
- Reset, then direct accept sel=5 with SEL_W=3 → next cycle y=8'b0010_0000, idx=5, y_valid=1; before the accept, y=0 and y_valid=0.
- Scan, dwell=2, start from 0 → idx steps 0,1,…,7,0 every 3 cycles; wrap pulses once, on the cycle idx returns to 0, 24 cycles after start.
- Scan dwell=0 with an accept of sel=6 coinciding with a step from idx=3 → idx=6, no wrap; next cycle idx=7, then 0 with wrap=1.
- en dropped for 10 cycles mid-scan at idx=4, count=1 (dwell=3) → y=0 and y_valid=0 throughout; on re-enable, y=8'b0001_0000, and idx=5 follows 2 cycles later.
- rst_n pulsed low for one cycle mid-scan at idx=6 → next cycle y=0, idx=0, wrap=0, state IDLE; the scan restarts from 0 when en && mode=1.
- SEL_W=4, dwell=1, mode toggled scan→direct at idx=9 → idx holds at 9 with y=16'h0200 until a direct accept of sel=15 gives y=16'h8000.

Source files
------------

// File: rtl/onehot_dec_pkg.sv
// Shared definitions for the one-hot scan decoder: FSM encodings and output width helper.
package onehot_dec_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DIRECT = ST_DIRECT,
    SCAN   = ST_SCAN
  } state_t;

  function automatic int onehot_width(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_dwell_timer.sv
// Dwell counter for scan stepping: counts 0..dwell and strobes step on the terminal count.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step
);

  logic [DWELL_W-1:0] cnt;

  // >= rather than == so that shrinking dwell below the current count steps at once
  assign step = run && (cnt >= dwell);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= step ? '0 : cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct (handshake) and auto-scan modes.
// state  | meaning
// IDLE   | no index decoded, outputs off
// DIRECT | drive the last accepted index
// SCAN   | step the index every dwell+1 cycles
module onehot_scan_decoder
  import onehot_dec_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  localparam int N       = onehot_width(SEL_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  state_t           state, state_next;
  logic [SEL_W-1:0] idx_next;
  logic             wrap_next;
  logic             accept;
  logic             run, clear, step;
  logic             out_on;

  assign sel_ready = en & rst_n;
  assign accept    = sel_valid & sel_ready;

  // The counter only advances while scanning; any other enabled cycle restarts it from 0.
  assign run   = en && (state == SCAN) && mode;
  assign clear = en && ((state != SCAN) || accept || !mode);

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (clear),
    .dwell (dwell),
    .step  (step)
  );

  always_comb begin
    state_next = state;
    idx_next   = idx;
    wrap_next  = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (mode) begin
            state_next = SCAN;
            idx_next   = accept ? sel : '0;
          end else if (accept) begin
            state_next = DIRECT;
            idx_next   = sel;
          end
        end
        DIRECT: begin
          if (accept) idx_next = sel;
          if (mode) state_next = SCAN;
        end
        SCAN: begin
          if (!mode) begin
            state_next = DIRECT;
            if (accept) idx_next = sel;
          end else if (accept) begin
            idx_next = sel;
          end else if (step) begin
            idx_next  = idx + SEL_W'(1);
            wrap_next = (idx == '1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign out_on = en && (state_next != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      wrap    <= 1'b0;
      y_valid <= 1'b0;
      y       <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      wrap    <= wrap_next;
      y_valid <= out_on;
      y       <= out_on ? (N'(1) << idx_next) : '0;
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Self-checking bench: SEL_W=3 and SEL_W=4 instances driven from vector tables and short sequences.
module tb_onehot_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, en_a, mode_a, sel_valid_a, sel_ready_a, y_valid_a, wrap_a;
  logic [2:0] sel_a, idx_a;
  logic [7:0] dwell_a, y_a;

  logic        rst_n_b, en_b, mode_b, sel_valid_b, sel_ready_b, y_valid_b, wrap_b;
  logic [3:0]  sel_b, idx_b;
  logic [7:0]  dwell_b;
  logic [15:0] y_b;

  onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .mode(mode_a), .sel(sel_a),
    .sel_valid(sel_valid_a), .sel_ready(sel_ready_a), .dwell(dwell_a),
    .y(y_a), .y_valid(y_valid_a), .idx(idx_a), .wrap(wrap_a)
  );

  onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .mode(mode_b), .sel(sel_b),
    .sel_valid(sel_valid_b), .sel_ready(sel_ready_b), .dwell(dwell_b),
    .y(y_b), .y_valid(y_valid_b), .idx(idx_b), .wrap(wrap_b)
  );

  typedef struct {
    logic [15:0] y;
    logic        y_valid;
    logic [3:0]  idx;
    logic        wrap;
    string       name;
  } exp_t;

  typedef struct {
    logic       r, e, m, v;
    logic [2:0] sel;
    logic [7:0] dwell;
    logic [7:0] y;
    logic       yv;
    logic [2:0] idx;
    logic       w;
    string      name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_front(input logic [15:0] y, input logic yv, input logic [3:0] i, input logic w);
    exp_t x;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    x = sb.pop_front();
    check({x.name, "/y"},       y,           x.y);
    check({x.name, "/y_valid"}, 16'(yv),     16'(x.y_valid));
    check({x.name, "/idx"},     16'(i),      16'(x.idx));
    check({x.name, "/wrap"},    16'(w),      16'(x.wrap));
  endtask

  task automatic cyc_a(input logic r, e, m, v, input logic [2:0] s, input logic [7:0] d,
                       input logic [7:0] ey, input logic ev, input logic [2:0] ei,
                       input logic ew, input string nm);
    exp_t x;
    rst_n_a = r; en_a = e; mode_a = m; sel_valid_a = v; sel_a = s; dwell_a = d;
    #1;
    check({nm, "/sel_ready"}, 16'(sel_ready_a), 16'(r & e));
    x.y = 16'(ey); x.y_valid = ev; x.idx = 4'(ei); x.wrap = ew; x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_front(16'(y_a), y_valid_a, 4'(idx_a), wrap_a);
  endtask

  task automatic cyc_b(input logic r, e, m, v, input logic [3:0] s, input logic [7:0] d,
                       input logic [15:0] ey, input logic ev, input logic [3:0] ei,
                       input logic ew, input string nm);
    exp_t x;
    rst_n_b = r; en_b = e; mode_b = m; sel_valid_b = v; sel_b = s; dwell_b = d;
    x.y = ey; x.y_valid = ev; x.idx = ei; x.wrap = ew; x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_front(y_b, y_valid_b, idx_b, wrap_b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  ea;
    logic [3:0]  eb;

    rst_n_a = 0; en_a = 0; mode_a = 0; sel_valid_a = 0; sel_a = '0; dwell_a = '0;
    rst_n_b = 0; en_b = 0; mode_b = 0; sel_valid_b = 0; sel_b = '0; dwell_b = '0;

    //            r  e  m  v  sel dwell y      yv idx w  name
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h00, 1'b0, 3'd0, 1'b0, "reset"};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 8'h00, 1'b0, 3'd0, 1'b0, "idle_no_accept"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 8'h20, 1'b1, 3'd5, 1'b0, "direct_sel5"};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0, 8'h20, 1'b1, 3'd5, 1'b0, "direct_hold"};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 8'd0, 8'h01, 1'b1, 3'd0, 1'b0, "direct_sel0"};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0, 8'h00, 1'b0, 3'd0, 1'b0, "disabled_no_accept"};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'd0, 8'h01, 1'b1, 3'd0, 1'b0, "reenable_direct"};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 8'd0, 8'h80, 1'b1, 3'd7, 1'b0, "direct_sel7"};

    for (int i = 0; i < 8; i++)
      cyc_a(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].v, vecs[i].sel, vecs[i].dwell,
            vecs[i].y, vecs[i].yv, vecs[i].idx, vecs[i].w, vecs[i].name);

    // Full rotation at dwell=2: one step per 3 cycles, single wrap 24 cycles after start.
    cyc_a(0, 0, 0, 0, 3'd0, 8'd0, 8'h00, 0, 3'd0, 0, "scan_reset");
    for (int c = 0; c <= 26; c++) begin
      ea = 3'((c / 3) % 8);
      cyc_a(1, 1, 1, 0, 3'd0, 8'd2, 8'(1) << ea, 1, ea, (c == 24), "scan_d2");
    end

    // Load in scan wins over a coincident step.
    cyc_a(0, 0, 0, 0, 3'd0, 8'd0, 8'h00, 0, 3'd0, 0, "load_reset");
    cyc_a(1, 1, 1, 1, 3'd3, 8'd0, 8'h08, 1, 3'd3, 0, "load_start3");
    cyc_a(1, 1, 1, 1, 3'd6, 8'd0, 8'h40, 1, 3'd6, 0, "load_wins");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd0, 8'h80, 1, 3'd7, 0, "load_step7");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd0, 8'h01, 1, 3'd0, 1, "load_wrap");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd0, 8'h02, 1, 3'd1, 0, "load_after_wrap");

    // Disable mid-scan at idx=4, count=1; resume preserves idx and count.
    cyc_a(0, 0, 0, 0, 3'd0, 8'd0, 8'h00, 0, 3'd0, 0, "en_reset");
    cyc_a(1, 1, 1, 1, 3'd4, 8'd3, 8'h10, 1, 3'd4, 0, "en_start4");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd3, 8'h10, 1, 3'd4, 0, "en_cnt1");
    for (int c = 0; c < 10; c++)
      cyc_a(1, 0, 1, 0, 3'd0, 8'd3, 8'h00, 0, 3'd4, 0, "en_off");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd3, 8'h10, 1, 3'd4, 0, "en_resume");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd3, 8'h10, 1, 3'd4, 0, "en_resume2");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd3, 8'h20, 1, 3'd5, 0, "en_step5");

    // Reset pulse mid-scan, then scan restarts from 0.
    cyc_a(0, 0, 0, 0, 3'd0, 8'd0, 8'h00, 0, 3'd0, 0, "rst_reset");
    cyc_a(1, 1, 1, 1, 3'd6, 8'd5, 8'h40, 1, 3'd6, 0, "rst_start6");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd5, 8'h40, 1, 3'd6, 0, "rst_hold6");
    cyc_a(0, 1, 1, 0, 3'd0, 8'd5, 8'h00, 0, 3'd0, 0, "rst_pulse");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd5, 8'h01, 1, 3'd0, 0, "rst_restart");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd5, 8'h01, 1, 3'd0, 0, "rst_restart2");

    // Shrinking dwell below the current count steps immediately.
    cyc_a(0, 0, 0, 0, 3'd0, 8'd0, 8'h00, 0, 3'd0, 0, "dw_reset");
    cyc_a(1, 1, 1, 1, 3'd0, 8'd7, 8'h01, 1, 3'd0, 0, "dw_start");
    for (int c = 0; c < 5; c++)
      cyc_a(1, 1, 1, 0, 3'd0, 8'd7, 8'h01, 1, 3'd0, 0, "dw_count");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd2, 8'h02, 1, 3'd1, 0, "dw_shrink_step");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd2, 8'h02, 1, 3'd1, 0, "dw_cnt1");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd2, 8'h02, 1, 3'd1, 0, "dw_cnt2");
    cyc_a(1, 1, 1, 0, 3'd0, 8'd2, 8'h04, 1, 3'd2, 0, "dw_step2");

    // SEL_W=4: scan at dwell=1 to idx 9, switch to direct, then accept 15.
    cyc_b(0, 0, 0, 0, 4'd0, 8'd0, 16'h0000, 0, 4'd0, 0, "b_reset");
    for (int c = 0; c <= 18; c++) begin
      eb = 4'(c / 2);
      cyc_b(1, 1, 1, 0, 4'd0, 8'd1, 16'(1) << eb, 1, eb, 0, "b_scan");
    end
    for (int c = 0; c < 3; c++)
      cyc_b(1, 1, 0, 0, 4'd0, 8'd1, 16'h0200, 1, 4'd9, 0, "b_direct_hold9");
    cyc_b(1, 1, 0, 1, 4'd15, 8'd1, 16'h8000, 1, 4'd15, 0, "b_direct_sel15");
    cyc_b(1, 1, 0, 0, 4'd0, 8'd1, 16'h8000, 1, 4'd15, 0, "b_direct_hold15");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
